// File: rtl/tx_packet_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tx_packet_assembler
// Brief    : Builds a header + payload TX packet from strobed byte commands and
//            hands it to the downstream stage with a valid/ready handshake.
//            Optional macro TX_ASM_PAD_CLEAR_EN: header accept zeroes payload.
// Revision : 1.0 - initial release
// ============================================================================
module tx_packet_assembler #(
  parameter  int MAX_BYTES = 16,
  parameter  int ID_W      = 2,
  parameter  int LEN_W     = 4,
  localparam int PKT_W     = 2*ID_W + LEN_W + 8*MAX_BYTES,
  localparam int CNT_W     = $clog2(MAX_BYTES+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [1:0]       mode,
  input  logic [7:0]       data,
  output logic [PKT_W-1:0] tx_packet,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             test_mode,
  output logic [1:0]       flag_status,
  output logic [CNT_W-1:0] byte_count,
  output logic             err_flag
);

  localparam logic [1:0] C_MODE_CLEAR = 2'b00;
  localparam logic [1:0] C_MODE_HDR   = 2'b01;
  localparam logic [1:0] C_MODE_DATA  = 2'b10;
  localparam logic [1:0] C_MODE_TEST  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;
  state_t w_eff_state;

  logic             r_load_d;
  logic [ID_W-1:0]  r_dest;
  logic [ID_W-1:0]  r_src;
  logic [LEN_W-1:0] r_len;
  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_payload [MAX_BYTES];
  logic             r_test_mode;
  logic             r_err;

  logic             w_cmd;
  logic             w_handshake;
  logic             w_clear;
  logic             w_hdr_accept;
  logic             w_data_write;
  logic             w_err_set;
  logic             w_test_load;
  logic [LEN_W-1:0] w_len_raw;
  logic             w_len_over;
  logic [LEN_W-1:0] w_len_clamped;
  logic [CNT_W-1:0] w_target;
  logic [CNT_W-1:0] w_count_inc;
  logic [8*MAX_BYTES-1:0] w_payload;

  assign w_cmd         = load & ~r_load_d;
  assign w_len_raw     = data[7-2*ID_W -: LEN_W];
  assign w_len_over    = {{(32-LEN_W){1'b0}}, w_len_raw} > 32'(MAX_BYTES);
  assign w_len_clamped = w_len_over ? LEN_W'(MAX_BYTES) : w_len_raw;
  assign w_target      = w_len_over ? CNT_W'(MAX_BYTES) : CNT_W'(w_len_raw);
  assign w_count_inc   = r_count + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_load_d <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_load_d <= load;
    end
  end

  // A handshake on the same edge as a command completes first, so the
  // command sees IDLE; clear overrides everything.
  always_comb begin
    w_handshake  = (r_state == S_DONE) && tx_ready;
    w_eff_state  = w_handshake ? S_IDLE : r_state;
    w_next_state = w_eff_state;
    w_clear      = 1'b0;
    w_hdr_accept = 1'b0;
    w_data_write = 1'b0;
    w_err_set    = 1'b0;
    w_test_load  = 1'b0;
    if (w_cmd) begin
      case (mode)
        C_MODE_CLEAR: begin
          w_clear      = 1'b1;
          w_next_state = S_IDLE;
        end
        C_MODE_HDR: begin
          if (w_eff_state != S_DONE) begin
            w_hdr_accept = 1'b1;
            w_err_set    = w_len_over;
            w_next_state = (w_target == '0) ? S_DONE : S_HDR;
          end else begin
            w_err_set = 1'b1;
          end
        end
        C_MODE_DATA: begin
          if (w_eff_state == S_HDR) begin
            w_data_write = 1'b1;
            w_next_state = (w_count_inc == r_target) ? S_DONE : S_HDR;
          end else begin
            w_err_set = 1'b1;
          end
        end
        C_MODE_TEST: w_test_load = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_dest      <= '0;
      r_src       <= '0;
      r_len       <= '0;
      r_target    <= '0;
      r_count     <= '0;
      r_test_mode <= 1'b0;
      r_err       <= 1'b0;
      for (int i = 0; i < MAX_BYTES; i++) r_payload[i] <= 8'h00;
    end else begin
      if (w_handshake) r_count <= '0;
      if (w_hdr_accept) begin
        r_dest   <= data[7 -: ID_W];
        r_src    <= data[7-ID_W -: ID_W];
        r_len    <= w_len_clamped;
        r_target <= w_target;
        r_count  <= '0;
`ifdef TX_ASM_PAD_CLEAR_EN
        for (int i = 0; i < MAX_BYTES; i++) r_payload[i] <= 8'h00;
`endif
      end
      if (w_data_write) begin
        r_count <= w_count_inc;
        for (int i = 0; i < MAX_BYTES; i++) begin
          if (r_count == CNT_W'(i)) r_payload[i] <= data;
        end
      end
      if (w_test_load) r_test_mode <= data[0];
      if (w_err_set)   r_err       <= 1'b1;
    end
  end

  // Byte 0 occupies the most significant payload byte.
  for (genvar g = 0; g < MAX_BYTES; g++) begin : g_pack
    assign w_payload[8*(MAX_BYTES-1-g) +: 8] = r_payload[g];
  end

  assign tx_packet   = {r_dest, r_src, r_len, w_payload};
  assign tx_valid    = (r_state == S_DONE);
  assign flag_status = {r_state != S_IDLE, r_state == S_DONE};
  assign byte_count  = r_count;
  assign test_mode   = r_test_mode;
  assign err_flag    = r_err;

endmodule
`default_nettype wire
